audio_avg_filter: RTL
=====================

# audio_avg_filter

Parametrised multi-channel moving-average noise filter for the audio path. It sits between the codec's ADC sample interface and the DAC sample interface. Each channel keeps a circular history of the last 2^LOG2_N samples and a running sum, and outputs the windowed mean. Depth, width and channel count are parameters, and a per-frame bypass is provided. Valid/ready handshakes on both sides tolerate DAC backpressure.

## Interface
Parameters:
- DATA_W, 24, signed sample width (two's complement)
- LOG2_N, 3, log2 of window depth; N = 2^LOG2_N, legal range 1..8
- CHANNELS, 2, channel count (2 = left/right)

Ports:
- CLOCK_50  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush of history, sums and output register
- bypass  in  1  when high, an accepted frame is output unfiltered
- in_valid  in  1  input frame present
- in_ready  out  1  filter can accept a frame this cycle
- in_data  in  CHANNELS*DATA_W  frame; channel c occupies bits [c*DATA_W +: DATA_W]
- out_valid  out  1  output frame present
- out_ready  in  1  downstream accepts output frame
- out_data  out  CHANNELS*DATA_W  filtered frame, same packing as in_data
- primed  out  1  at least N frames accepted since last reset/clear

## Operation
- Accept = in_valid && in_ready && !clear. in_ready = (!out_valid || out_ready) && !clear.
- On accept, for every channel c, in parallel:
  - x = new sample; old = hist[c][wptr]; sum_next = sum[c] + x - old.
  - hist[c][wptr] <= x; sum[c] <= sum_next.
  - out lane c <= bypass ? x : sum_next >>> LOG2_N (arithmetic shift, floor toward -inf).
- wptr (LOG2_N bits) is shared by all channels, increments per accept and wraps N-1 -> 0.
- out_valid <= 1 on accept. Otherwise it is cleared when out_valid && out_ready.
- Sums and history update even in bypass, so de-asserting bypass resumes filtering with no transient.
- Sum width: DATA_W+LOG2_N signed, so it cannot overflow. The output is the low DATA_W bits of the shifted sum and always fits.
- Warm-up: history resets to zero, so the first N outputs ramp (sum/N with zeros for missing samples).
- fill counter: saturates at N. primed = (fill == N).
- clear (synchronous): hist, sum, wptr and fill are zeroed; out_valid <= 0. A frame offered in the same cycle is not accepted. clear overrides a pending output (the frame is dropped).
- Simultaneous output drain and accept: out_valid stays 1 and out_data takes the new frame (full throughput, one frame/cycle).

## Timing
- Reset (reset_n low, async): out_valid=0, out_data=0, primed=0, all hist/sum/wptr/fill=0. in_ready=1 after reset once clear is low.
- Latency: accept in cycle k -> out_valid and out_data valid from cycle k+1.
- out_data and out_valid are held stable while out_valid && !out_ready.
- in_ready is combinational from out_valid, out_ready and clear. There is no combinational path from in_valid to in_ready.
- Reset asserted mid-stream discards history and the pending output immediately. The first frame after release starts a new warm-up.

## Structure
- Package audio_filt_pkg:
  - default DATA_W/LOG2_N/CHANNELS localparams
  - function for lane extract/insert of packed frames
- Sub-module audio_avg_channel, instantiated CHANNELS times via generate. It owns one channel's:
  - history array (N x DATA_W registers)
  - running sum
  - output-lane mux
- It takes the shared wptr, accept, clear and bypass.
- Top level owns wptr, fill/primed, the handshake and the out_valid register.

## Test plan
Configuration for all scenarios: DATA_W=24, LOG2_N=3, CHANNELS=2, out_ready=1 unless stated.
- Step: ch0 held at 800, ch1 at -800 for 12 frames -> ch0 outputs 100,200,…,800 then 800 steady; ch1 -100…-800 then -800. primed rises with the 8th output.
- Rounding: ch0 = -1 constant -> outputs -1 every frame (floor). ch0 alternating 1,0 -> 0 until primed, then 0 (sum 4 >>> 3).
- Extremes: ch0 = 0x7FFFFF, ch1 = 0x800000 for 10 frames -> steady outputs exactly 0x7FFFFF and 0x800000, no wrap.
- Backpressure: out_ready low for 5 cycles with in_valid high -> in_ready low, out_data frozen, no history update. On release, one frame per cycle, with no sample lost or duplicated versus a reference model.
- Bypass toggle: bypass high for frames 3-6 of a ramp -> those outputs equal the raw input. Frame 7 equals the true 8-sample mean.
- Clear/reset mid-stream: clear at frame 5 -> out_valid 0 next cycle, primed 0, and the next output is x/8. Repeat with reset_n pulsed asynchronously between clock edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/audio_filt_pkg.sv
// Shared defaults and packed-frame lane helpers for the moving-average audio filter.
package audio_filt_pkg;

  localparam int unsigned DATA_W_DEF   = 24;
  localparam int unsigned LOG2_N_DEF   = 3;
  localparam int unsigned CHANNELS_DEF = 2;

  // Helpers work on generously sized containers; callers cast to their real widths.
  localparam int unsigned LANE_MAX_W  = 32;
  localparam int unsigned FRAME_MAX_W = 512;

  function automatic logic [LANE_MAX_W-1:0] lane_get(
    input logic [FRAME_MAX_W-1:0] frame,
    input int unsigned            lane,
    input int unsigned            lane_w
  );
    return LANE_MAX_W'(frame >> (lane * lane_w));
  endfunction

  function automatic logic [FRAME_MAX_W-1:0] lane_put(
    input logic [FRAME_MAX_W-1:0] frame,
    input int unsigned            lane,
    input int unsigned            lane_w,
    input logic [LANE_MAX_W-1:0]  value
  );
    logic [FRAME_MAX_W-1:0] mask;
    mask = (FRAME_MAX_W'(1) << lane_w) - FRAME_MAX_W'(1);
    return (frame & ~(mask << (lane * lane_w))) |
           ((FRAME_MAX_W'(value) & mask) << (lane * lane_w));
  endfunction

endpackage

// File: rtl/audio_avg_channel.sv
// One channel of the moving-average filter: circular history, running sum and
// registered output lane (mean or raw sample when bypassed).
module audio_avg_channel
  import audio_filt_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LOG2_N = LOG2_N_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     accept,
  input  logic                     clear,
  input  logic                     bypass,
  input  logic [LOG2_N-1:0]        wptr,
  input  logic signed [DATA_W-1:0] sample,
  output logic signed [DATA_W-1:0] out_lane
);

  localparam int unsigned N     = 1 << LOG2_N;
  localparam int unsigned SUM_W = DATA_W + LOG2_N;

  logic signed [DATA_W-1:0] hist [N];
  logic signed [SUM_W-1:0]  sum;
  logic signed [SUM_W-1:0]  sum_next;
  logic signed [DATA_W-1:0] oldest;

  // Sum is wide enough to hold N full-scale samples, so it never wraps.
  assign oldest   = hist[wptr];
  assign sum_next = sum + SUM_W'(sample) - SUM_W'(oldest);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum      <= '0;
      out_lane <= '0;
      for (int unsigned i = 0; i < N; i++) hist[i] <= '0;
    end else if (clear) begin
      sum      <= '0;
      out_lane <= '0;
      for (int unsigned i = 0; i < N; i++) hist[i] <= '0;
    end else if (accept) begin
      hist[wptr] <= sample;
      sum        <= sum_next;
      out_lane   <= bypass ? sample : DATA_W'(sum_next >>> LOG2_N);
    end
  end

endmodule

// File: rtl/audio_avg_filter.sv
// Multi-channel moving-average filter between ADC and DAC sample streams,
// with valid/ready handshakes, per-frame bypass and synchronous clear.
module audio_avg_filter
  import audio_filt_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned LOG2_N   = LOG2_N_DEF,
  parameter int unsigned CHANNELS = CHANNELS_DEF
) (
  input  logic                         CLOCK_50,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         bypass,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         primed
);

  localparam int unsigned N      = 1 << LOG2_N;
  localparam int unsigned FILL_W = LOG2_N + 1;

  logic              accept_c;
  logic [LOG2_N-1:0] wptr;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_next;

  // Ready depends only on the output register, downstream ready and clear.
  assign in_ready  = (!out_valid || out_ready) && !clear;
  assign accept_c  = in_valid && in_ready;
  assign fill_next = (fill == FILL_W'(N)) ? fill : fill + FILL_W'(1);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      wptr      <= '0;
      fill      <= '0;
      primed    <= 1'b0;
      out_valid <= 1'b0;
    end else if (clear) begin
      wptr      <= '0;
      fill      <= '0;
      primed    <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept_c) begin
      wptr      <= wptr + LOG2_N'(1);
      fill      <= fill_next;
      primed    <= (fill_next == FILL_W'(N));
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [DATA_W-1:0] sample;
    logic signed [DATA_W-1:0] lane;

    assign sample = DATA_W'(lane_get(FRAME_MAX_W'(in_data), c, DATA_W));

    audio_avg_channel #(
      .DATA_W (DATA_W),
      .LOG2_N (LOG2_N)
    ) u_ch (
      .clk      (CLOCK_50),
      .rst_n    (reset_n),
      .accept   (accept_c),
      .clear    (clear),
      .bypass   (bypass),
      .wptr     (wptr),
      .sample   (sample),
      .out_lane (lane)
    );

    assign out_data[c*DATA_W +: DATA_W] = lane;
  end

endmodule
